// File: rtl/nco_sweep_ctrl_pkg.sv
// Shared types and default widths for the NCO frequency-sweep controller.
package nco_sweep_ctrl_pkg;

  localparam int TW_WIDTH_DEF    = 32;
  localparam int DWELL_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DWELL = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_e;

  // True for the states in which a sweep is in progress.
  function automatic logic is_active_state(input sweep_state_e st);
    return (st == ST_LOAD) || (st == ST_DWELL) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/nco_step_clamp.sv
// Combinational +/- step toward a target word.
// Overflow, underflow, landing on the target or overshooting it all clamp
// to the target. A zero step jumps straight to the target.
module nco_step_clamp
  import nco_sweep_ctrl_pkg::*;
#(
  parameter int W = TW_WIDTH_DEF
) (
  input  logic [W-1:0] cur_word,
  input  logic [W-1:0] step,
  input  logic [W-1:0] target,
  input  logic         descend,
  output logic [W-1:0] next_word,
  output logic         at_target
);

  logic [W:0] sum_s;
  logic [W:0] diff_s;

  // Next word selection with carry/borrow-aware clamping.
  always_comb begin
    sum_s     = {1'b0, cur_word} + {1'b0, step};
    diff_s    = {1'b0, cur_word} - {1'b0, step};
    at_target = (cur_word == target);
    next_word = target;
    if (step == {W{1'b0}}) begin
      next_word = target;
    end else if (!descend) begin
      if (sum_s[W] || (sum_s[W-1:0] >= target)) begin
        next_word = target;
      end else begin
        next_word = sum_s[W-1:0];
      end
    end else begin
      if (diff_s[W] || (diff_s[W-1:0] <= target)) begin
        next_word = target;
      end else begin
        next_word = diff_s[W-1:0];
      end
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller producing the NCO tuning word.
// Optional build macro NCO_SWEEP_TRI_EN: continuous mode bounces between
// the endpoints (triangle) instead of restarting from f_start (sawtooth).
module nco_sweep_ctrl
  import nco_sweep_ctrl_pkg::*;
#(
  parameter int TW_WIDTH    = TW_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
  input  logic                   clk_top,
  input  logic                   rst_top,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cont,
  input  logic [TW_WIDTH-1:0]    f_start,
  input  logic [TW_WIDTH-1:0]    f_stop,
  input  logic [TW_WIDTH-1:0]    f_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [TW_WIDTH-1:0]    tuning_word,
  output logic                   busy,
  output logic                   done,
  output logic                   sweep_dir
);

  sweep_state_e           state_r;
  logic [TW_WIDTH-1:0]    cfg_start_r;
  logic [TW_WIDTH-1:0]    cfg_stop_r;
  logic [TW_WIDTH-1:0]    cfg_step_r;
  logic [DWELL_WIDTH-1:0] cfg_dwell_r;
  logic                   cfg_cont_r;
  logic [DWELL_WIDTH-1:0] dwell_cnt_r;
  logic [TW_WIDTH-1:0]    next_word_s;
  logic                   at_target_s;

  nco_step_clamp #(.W(TW_WIDTH)) u_step_clamp (
    .cur_word  (tuning_word),
    .step      (cfg_step_r),
    .target    (cfg_stop_r),
    .descend   (sweep_dir),
    .next_word (next_word_s),
    .at_target (at_target_s)
  );

  // Sweep FSM with dwell counter, latched configuration and registered outputs.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      state_r     <= ST_IDLE;
      tuning_word <= {TW_WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      sweep_dir   <= 1'b0;
      dwell_cnt_r <= {DWELL_WIDTH{1'b0}};
      cfg_start_r <= {TW_WIDTH{1'b0}};
      cfg_stop_r  <= {TW_WIDTH{1'b0}};
      cfg_step_r  <= {TW_WIDTH{1'b0}};
      cfg_dwell_r <= {DWELL_WIDTH{1'b0}};
      cfg_cont_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && (state_r != ST_IDLE)) begin
        // Abort: the word freezes where it is, no completion pulse.
        state_r <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && !stop) begin
              cfg_start_r <= f_start;
              cfg_stop_r  <= f_stop;
              cfg_step_r  <= f_step;
              cfg_dwell_r <= dwell;
              cfg_cont_r  <= cont;
              state_r     <= ST_LOAD;
              busy        <= 1'b1;
            end else begin
              busy <= 1'b0;
            end
          end
          ST_LOAD: begin
            tuning_word <= cfg_start_r;
            sweep_dir   <= (cfg_stop_r < cfg_start_r);
            dwell_cnt_r <= cfg_dwell_r;
            state_r     <= ST_DWELL;
            busy        <= 1'b1;
          end
          ST_DWELL: begin
            busy <= 1'b1;
            if (dwell_cnt_r != {DWELL_WIDTH{1'b0}}) begin
              dwell_cnt_r <= dwell_cnt_r - {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
            end else if (!at_target_s) begin
              state_r <= ST_STEP;
            end else if (cfg_cont_r) begin
              done <= 1'b1;
`ifdef NCO_SWEEP_TRI_EN
              // Turn around: the old start becomes the new target.
              cfg_start_r <= cfg_stop_r;
              cfg_stop_r  <= cfg_start_r;
              sweep_dir   <= ~sweep_dir;
              state_r     <= ST_STEP;
`else
              state_r     <= ST_LOAD;
`endif
            end else begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_DONE;
            end
          end
          ST_STEP: begin
            tuning_word <= next_word_s;
            dwell_cnt_r <= cfg_dwell_r;
            state_r     <= ST_DWELL;
            busy        <= 1'b1;
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: a word-list model expands each sweep
// into a per-cycle expected trace; a monitor pops it while the DUT is active.
module tb_nco_sweep_ctrl;

  logic        clk_top = 1'b0;
  logic        rst_top = 1'b0;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic        cont    = 1'b0;
  logic [31:0] f_start = 32'd0;
  logic [31:0] f_stop  = 32'd0;
  logic [31:0] f_step  = 32'd0;
  logic [15:0] dwell   = 16'd0;
  logic [31:0] tuning_word;
  logic        busy;
  logic        done;
  logic        sweep_dir;

  nco_sweep_ctrl #(.TW_WIDTH(32), .DWELL_WIDTH(16)) dut (
    .clk_top     (clk_top),
    .rst_top     (rst_top),
    .start       (start),
    .stop        (stop),
    .cont        (cont),
    .f_start     (f_start),
    .f_stop      (f_stop),
    .f_step      (f_step),
    .dwell       (dwell),
    .tuning_word (tuning_word),
    .busy        (busy),
    .done        (done),
    .sweep_dir   (sweep_dir)
  );

  always #5 clk_top = ~clk_top;

  typedef struct packed {
    logic [31:0] tw;
    logic        busy;
    logic        done;
    logic        dir;
  } obs_t;

  obs_t   exp_q[$];
  longint words_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     mon_en   = 1'b0;
  logic [31:0] last_tw  = 32'd0;
  logic        last_dir = 1'b0;
  obs_t   mon_act;
  obs_t   mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT is busy or pulsing done, compare with the next expectation.
  always @(posedge clk_top) begin
    #1;
    if (mon_en && rst_top && (busy || done)) begin
      mon_act = '{tw: tuning_word, busy: busy, done: done, dir: sweep_dir};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got tw=%0h busy=%0b done=%0b dir=%0b, expected idle",
                 tuning_word, busy, done, sweep_dir);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL scoreboard: got tw=%0h busy=%0b done=%0b dir=%0b, expected tw=%0h busy=%0b done=%0b dir=%0b",
                   mon_act.tw, mon_act.busy, mon_act.done, mon_act.dir,
                   mon_exp.tw, mon_exp.busy, mon_exp.done, mon_exp.dir);
        end
      end
    end
  end

  // Word list of one sweep, from plain 64-bit arithmetic.
  task automatic model_words(input longint fs, input longint fe, input longint st);
    longint w;
    w = fs;
    words_q.delete();
    words_q.push_back(w);
    while (w != fe) begin
      if (st == 0) w = fe;
      else if (fe > fs) w = ((fe - w) <= st) ? fe : w + st;
      else w = ((w - fe) <= st) ? fe : w - st;
      words_q.push_back(w);
    end
  endtask

  // Run one sweep; stop_at >= 0 aborts during that trace entry (entry 0 = LOAD cycle).
  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                           input int dw, input bit c, input int stop_at);
    obs_t        trace[$];
    logic        dir;
    logic [31:0] w;
    int          k;
    int          t;
    model_words(fs, fe, st);
    k   = words_q.size();
    dir = (fe < fs);
    trace.push_back('{tw: last_tw, busy: 1'b1, done: 1'b0, dir: last_dir});
    do begin
      for (int i = 0; i < k; i++) begin
        w = 32'(words_q[i]);
        for (int d = 0; d <= dw; d++) trace.push_back('{tw: w, busy: 1'b1, done: 1'b0, dir: dir});
        if (i < k - 1) trace.push_back('{tw: w, busy: 1'b1, done: 1'b0, dir: dir});
      end
      w = 32'(words_q[k-1]);
      if (c) trace.push_back('{tw: w, busy: 1'b1, done: 1'b1, dir: dir});
      else   trace.push_back('{tw: w, busy: 1'b0, done: 1'b1, dir: dir});
    end while (c && (trace.size() <= stop_at));
    if (stop_at >= 0) begin
      while (trace.size() > stop_at + 1) void'(trace.pop_back());
    end
    foreach (trace[i]) exp_q.push_back(trace[i]);

    @(negedge clk_top);
    f_start = fs; f_stop = fe; f_step = st; dwell = 16'(dw); cont = c; start = 1'b1;
    @(negedge clk_top);
    start = 1'b0;
    f_start = $urandom; f_stop = $urandom; f_step = $urandom; dwell = 16'($urandom_range(0, 5));
    cont = ~c;
    if (stop_at >= 0) begin
      repeat (stop_at) @(negedge clk_top);
      stop = 1'b1;
      @(negedge clk_top);
      stop = 1'b0;
    end else begin
      @(negedge clk_top);
      start = 1'b1;
      @(negedge clk_top);
      start = 1'b0;
    end
    t = 0;
    while ((exp_q.size() != 0) && (t < 5000)) begin
      @(negedge clk_top);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sweep_timeout: got %0d pending entries, expected 0", exp_q.size());
      exp_q.delete();
    end
    last_tw  = trace[trace.size()-1].tw;
    last_dir = trace[trace.size()-1].dir;
    @(negedge clk_top);
    @(negedge clk_top);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_tw",   64'(tuning_word), 64'(last_tw));
    check("idle_dir",  64'(sweep_dir), 64'(last_dir));
  endtask

  initial begin
    longint fs_l;
    longint fe_l;
    int     delta;
    int     sa;
    logic [31:0] st_r;

    #3;
    check("reset_tw",   64'(tuning_word), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dir",  64'(sweep_dir), 64'd0);
    @(negedge clk_top);
    rst_top = 1'b1;
    mon_en  = 1'b1;

    run_sweep(32'd100, 32'd130, 32'd10, 2, 1'b0, -1);
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 1'b0, -1);
    run_sweep(32'd500, 32'd470, 32'd20, 0, 1'b0, -1);
    run_sweep(32'd10, 32'd30, 32'd10, 1, 1'b1, 4);
    check("stop_holds_word", 64'(tuning_word), 64'd20);
    run_sweep(32'd5, 32'd9, 32'd0, 1, 1'b0, -1);
    run_sweep(32'd77, 32'd77, 32'd5, 2, 1'b0, -1);
    run_sweep(32'd10, 32'd30, 32'd10, 0, 1'b1, 12);
    run_sweep(32'd20, 32'd3, 32'd7, 0, 1'b0, -1);

    // start together with stop from idle must not launch a sweep
    @(negedge clk_top);
    f_start = 32'd1000; f_stop = 32'd1100; f_step = 32'd50; dwell = 16'd0; cont = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(negedge clk_top);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk_top);
    check("start_stop_busy", 64'(busy), 64'd0);
    check("start_stop_tw",   64'(tuning_word), 64'(last_tw));

    for (int i = 0; i < 8; i++) begin
      delta = $urandom_range(0, 80);
      st_r  = ($urandom_range(0, 6) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
      if (i == 0)      fs_l = longint'(32'hFFFF_FFFF) - $urandom_range(0, 40);
      else if (i == 1) fs_l = $urandom_range(0, 40);
      else             fs_l = longint'($urandom);
      if ((i == 0) || ((i > 1) && ($urandom_range(0, 1) == 1))) begin
        fe_l = fs_l + delta;
        if (fe_l > longint'(32'hFFFF_FFFF)) fe_l = longint'(32'hFFFF_FFFF);
      end else begin
        fe_l = fs_l - delta;
        if (fe_l < 0) fe_l = 0;
      end
      sa = (i % 3 == 2) ? $urandom_range(1, 30) : -1;
      run_sweep(32'(fs_l), 32'(fe_l), st_r, $urandom_range(0, 3), (sa >= 0), sa);
    end

    // asynchronous reset during a STEP cycle of a descending sweep
    mon_en = 1'b0;
    exp_q.delete();
    @(negedge clk_top);
    f_start = 32'd500; f_stop = 32'd470; f_step = 32'd20; dwell = 16'd0; cont = 1'b0; start = 1'b1;
    @(negedge clk_top);
    start = 1'b0;
    repeat (2) @(negedge clk_top);
    check("pre_reset_dir", 64'(sweep_dir), 64'd1);
    #2;
    rst_top = 1'b0;
    #1;
    check("async_reset_tw",   64'(tuning_word), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    check("async_reset_dir",  64'(sweep_dir), 64'd0);
    @(negedge clk_top);
    rst_top  = 1'b1;
    last_tw  = 32'd0;
    last_dir = 1'b0;
    mon_en   = 1'b1;
    run_sweep(32'd1, 32'd3, 32'd1, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
